// File: rtl/adder_pkg.sv
// Shared types for the two-requester adder arbiter.
package adder_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/sixteenbit_adder.sv
// 16-bit modulo adder with signed-overflow flag.
module sixteenbit_adder
    import adder_pkg::*;
(
    input  word_t a,
    input  word_t b,
    output word_t f,
    output logic  ovf
);

    // Wrap-around sum; overflow when like-signed operands give an unlike-signed result.
    always_comb begin
        f   = a + b;
        ovf = (a[WORD_W-1] == b[WORD_W-1]) && (f[WORD_W-1] != a[WORD_W-1]);
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one sixteenbit_adder between two requesters.
// Optional statistics ports/counters are built when ADDER_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | offering req_ready to the granted requester
// CALC  | operands latched, adder result captured at the next edge
// RESP  | rsp_valid high, result held until rsp_ready
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_f,
    output logic                  rsp_ovf,
    output logic                  rsp_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]           stat_grant0,
    output logic [15:0]           stat_grant1,
    output logic [15:0]           stat_ovf
`endif
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    word_t      a_q, a_d;
    word_t      b_q, b_d;
    logic       id_q, id_d;
    word_t      f_q, f_d;
    logic       ovf_q, ovf_d;

    logic       grant;
    logic       accept;
    logic       rsp_hs;
    word_t      sum;
    logic       sum_ovf;

    sixteenbit_adder u_adder (
        .a   (a_q),
        .b   (b_q),
        .f   (sum),
        .ovf (sum_ovf)
    );

    // Round-robin pick: a lone requester wins, a tie goes away from last_grant.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; everything is held quiet while reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        if (!rst && (state_q == IDLE) && req_valid[grant]) begin
            req_ready[grant] = 1'b1;
        end
        rsp_valid = !rst && (state_q == RESP);
        accept    = |(req_valid & req_ready);
        rsp_hs    = rsp_valid && rsp_ready;
        rsp_f     = f_q;
        rsp_ovf   = ovf_q;
        rsp_id    = id_q;
    end

    // Operand capture on accept, result capture in CALC, grant history on response.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        f_d          = f_q;
        ovf_d        = ovf_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            a_d  = req_a[grant];
            b_d  = req_b[grant];
            id_d = grant;
        end
        if (state_q == CALC) begin
            f_d   = sum;
            ovf_d = sum_ovf;
        end
        if (rsp_hs) begin
            last_grant_d = id_q;
        end
    end

    // Datapath registers; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            f_q          <= '0;
            ovf_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            f_q          <= f_d;
            ovf_q        <= ovf_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] stat_grant0_q, stat_grant0_d;
    logic [15:0] stat_grant1_q, stat_grant1_d;
    logic [15:0] stat_ovf_q, stat_ovf_d;

    // Saturating event counters.
    always_comb begin
        stat_grant0_d = stat_grant0_q;
        stat_grant1_d = stat_grant1_q;
        stat_ovf_d    = stat_ovf_q;
        if (accept && !grant && (stat_grant0_q != 16'hFFFF)) begin
            stat_grant0_d = stat_grant0_q + 16'd1;
        end
        if (accept && grant && (stat_grant1_q != 16'hFFFF)) begin
            stat_grant1_d = stat_grant1_q + 16'd1;
        end
        if (rsp_hs && ovf_q && (stat_ovf_q != 16'hFFFF)) begin
            stat_ovf_d = stat_ovf_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0_q <= '0;
            stat_grant1_q <= '0;
            stat_ovf_q    <= '0;
        end else begin
            stat_grant0_q <= stat_grant0_d;
            stat_grant1_q <= stat_grant1_d;
            stat_ovf_q    <= stat_ovf_d;
        end
    end

    assign stat_grant0 = stat_grant0_q;
    assign stat_grant1 = stat_grant1_q;
    assign stat_ovf    = stat_ovf_q;
`endif

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width (only 16 supported; matches sixteenbit_adder).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid  input  2, req_ready  output  2  per-requester handshake (bit i = requester i).
REQ-005 SHALL have ports: req_a, req_b  input  2x16  operands per requester.
REQ-006 SHALL have ports: rsp_valid  output  1, rsp_ready  input  1  result handshake.
REQ-007 SHALL have ports: rsp_f  output  16 sum; rsp_ovf  output  1 signed overflow; rsp_id  output  1 requester served.
REQ-008 SHALL have, with ADDER_ARB_STATS_EN defined only: stat_grant0, stat_grant1, stat_ovf  output  16 each.

Function
REQ-009 SHALL share one sixteenbit_adder between two requesters, one operation in flight.
REQ-010 SHALL implement FSM IDLE -> CALC -> RESP -> IDLE.
REQ-011 IDLE: req_ready[i] SHALL be 1 only for the granted requester, combinationally; other bit 0; both 0 outside IDLE.
REQ-012 Grant SHALL be round-robin: single valid requester wins; both valid -> requester other than last_grant wins.
REQ-013 Accept (valid && ready) at edge N SHALL latch a, b, id and go to CALC.
REQ-014 CALC: adder output f, ovf SHALL be registered into rsp_f, rsp_ovf at edge N+1; go to RESP.
REQ-015 rsp_valid SHALL be 1 from cycle after edge N+1 until rsp_valid && rsp_ready; rsp_f/rsp_ovf/rsp_id stable meanwhile.
REQ-016 On response handshake SHALL return to IDLE and update last_grant = rsp_id; no new request accepted in that cycle (max throughput 1 op / 3 cycles).
REQ-017 Sum SHALL be modulo 2^16; ovf = 1 when operands share sign bit and result sign differs.
REQ-018 Requester deasserting req_valid while not accepted SHALL have no effect; no request dropped once accepted.

Reset
REQ-019 rst SHALL force state IDLE, rsp_valid 0, rsp_f 0x0000, rsp_ovf 0, rsp_id 0, last_grant 1 (requester 0 wins first tie), req_ready 2'b00 while rst high.
REQ-020 rst in CALC or RESP SHALL abort the operation; no response produced.
REQ-021 Statistics counters SHALL reset to 0.

Configuration
REQ-022 Macro ADDER_ARB_STATS_EN SHALL, when defined, add stat ports: grant counter per requester (increments on accept), overflow counter (increments on response handshake with rsp_ovf=1), all saturating at 0xFFFF.
REQ-023 Without ADDER_ARB_STATS_EN, stat ports and counters SHALL be absent; other behaviour identical.

Structure
REQ-024 Package adder_pkg SHALL hold WORD_W=16, word_t typedef, arb_state_t enum {IDLE, CALC, RESP}.
REQ-025 SHALL instantiate exactly one sixteenbit_adder (ports a, b, f, ovf) as the sole sub-module.

Verification
REQ-026 req0 0x0025+0x0045, rsp_ready=1 -> rsp_f 0x006A, ovf 0, id 0, rsp_valid 2 cycles after accept.
REQ-027 req1 0x7FFF+0x7FFF -> 0xFFFE, ovf 1; req0 0x9D00+0x9E00 -> 0x3B00, ovf 1; 0x8A10+0x7110 -> 0xFB20, ovf 0.
REQ-028 Both valid from reset (0xFFFF+0xFFFF on 0, 0x0000+0x0000 on 1) -> id 0 first (0xFFFE, ovf 0), then id 1 (0x0000, ovf 0).
REQ-029 rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_f, rsp_id held; req_ready stays 2'b00.
REQ-030 rst pulsed in CALC -> no rsp_valid; next request from requester 0 served normally.
REQ-031 With ADDER_ARB_STATS_EN: 3 req0 ops, 1 req1 op, 2 overflows -> stat_grant0 3, stat_grant1 1, stat_ovf 2.
